// File: rtl/data_accum_pkg.sv
// Shared types and helpers for the coherent averaging accumulator: state encoding,
// pointer width and the saturating add used by the write pipeline.
package data_accum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT_TRIG,
    ST_DRAIN,
    ST_READOUT
  } state_e;

  typedef struct packed {
    logic signed [31:0] sum;
    logic               ovf;
  } sat_res_t;

  function automatic int ptr_width(input int record_len);
    return $clog2(record_len);
  endfunction

  // Adds at 33 bits then clamps to the signed range of an acc_w-bit word (acc_w <= 31).
  function automatic sat_res_t sat_add(input logic signed [31:0] a,
                                       input logic signed [31:0] b,
                                       input int                 acc_w);
    logic signed [32:0] full;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sat_res_t           r;
    full  = 33'(a) + 33'(b);
    hi    = (33'sd1 <<< (acc_w - 1)) - 33'sd1;
    lo    = -(33'sd1 <<< (acc_w - 1));
    r.sum = full[31:0];
    r.ovf = 1'b0;
    if (full > hi) begin
      r.sum = hi[31:0];
      r.ovf = 1'b1;
    end else if (full < lo) begin
      r.sum = lo[31:0];
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_sat_adder.sv
// Write-pipeline S1 register (index, sign-extended sample, first-pass flag) feeding the S2
// add/clamp; the sum is written to memory on the following edge. No backpressure.
module accum_sat_adder
  import data_accum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int IDX_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    smp_vld,
  input  logic [IDX_W-1:0]        smp_idx,
  input  logic signed [DATA_W-1:0] smp_dat,
  input  logic                    smp_first,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic                    wr_vld,
  output logic [IDX_W-1:0]        wr_idx,
  output logic signed [ACC_W-1:0] wr_dat,
  output logic                    ovf
);

  logic                    vld_q, vld_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] dat_q, dat_d;
  logic                    first_q, first_d;
  sat_res_t                res;
  logic                    unused_sum_hi;

  always_comb begin
    vld_d   = smp_vld;
    idx_d   = smp_idx;
    dat_d   = ACC_W'(smp_dat);
    first_d = smp_first;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= 1'b0;
      idx_q   <= '0;
      dat_q   <= '0;
      first_q <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      first_q <= first_d;
    end
  end

  // The first pass overwrites whatever an earlier record left behind.
  always_comb begin
    res           = sat_add(32'(acc_in), 32'(dat_q), ACC_W);
    unused_sum_hi = ^res.sum[31:ACC_W];
    wr_vld        = vld_q;
    wr_idx        = idx_q;
    wr_dat        = first_q ? dat_q : res.sum[ACC_W-1:0];
    ovf           = vld_q & ~first_q & res.ovf;
  end

endmodule

// File: rtl/data_accumulator_avg.sv
// Captures RECORD_LEN samples per strobe, sums numAverages passes with saturation, then streams
// the record out; first word 3 cycles after the last sample, each further word 2 cycles after dataRead.
module data_accumulator_avg
  import data_accum_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16,
  parameter int RECORD_LEN = 128,
  parameter int AVG_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inputData,
  input  logic              dataCaptureStrobe,
  input  logic [AVG_W-1:0]  numAverages,
  input  logic              abortCapture,
  input  logic              dataRead,
  output logic              dataReadyToRead,
  output logic              dataEmpty,
  output logic [ACC_W-1:0]  dataOut,
  output logic              captureBusy,
  output logic              overflowFlag
);

  localparam int               PTR_W    = ptr_width(RECORD_LEN);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RECORD_LEN - 1);

  state_e             state_q, state_d;
  logic [AVG_W-1:0]   pass_q, pass_d;
  logic [AVG_W-1:0]   navg_q, navg_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;
  logic               ready_q, ready_d;
  logic               empty_q, empty_d;
  logic [ACC_W-1:0]   dout_q, dout_d;
  logic               fill1_q, fill1_d;
  logic               fill2_q, fill2_d;

  logic                    smp_vld;
  logic                    smp_first;
  logic                    wr_vld;
  logic [PTR_W-1:0]        wr_idx;
  logic signed [ACC_W-1:0] wr_dat;
  logic                    add_ovf;
  logic [PTR_W-1:0]        rd_addr;
  logic signed [ACC_W-1:0] mem [RECORD_LEN];
  logic signed [ACC_W-1:0] mem_rd_q;

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    navg_d    = navg_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q | add_ovf;
    ready_d   = ready_q;
    empty_d   = empty_q;
    dout_d    = dout_q;
    fill1_d   = 1'b0;
    fill2_d   = fill1_q;
    smp_vld   = 1'b0;
    smp_first = (pass_q == '0);
    if (abortCapture) begin
      state_d  = ST_IDLE;
      pass_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      ready_d  = 1'b0;
      empty_d  = 1'b1;
      fill2_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (dataCaptureStrobe) begin
          state_d   = ST_CAPTURE;
          pass_d    = '0;
          navg_d    = (numAverages == '0) ? AVG_W'(1) : numAverages;
          ovf_d     = 1'b0;
          empty_d   = 1'b0;
          smp_vld   = 1'b1;
          smp_first = 1'b1;
          wr_ptr_d  = wr_ptr_q + 1'b1;
        end
        ST_WAIT_TRIG: if (dataCaptureStrobe) begin
          state_d  = ST_CAPTURE;
          smp_vld  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        ST_CAPTURE: begin
          smp_vld  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == PTR_LAST) begin
            if (pass_q == navg_q - AVG_W'(1)) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_WAIT_TRIG;
              pass_d  = pass_q + 1'b1;
            end
          end
        end
        // The read port already points at rd_ptr here, so word 0 is fetched on the way out.
        ST_DRAIN: if (!wr_vld) begin
          state_d = ST_READOUT;
          fill2_d = 1'b1;
        end
        ST_READOUT: if (dataRead && ready_q) begin
          ready_d = 1'b0;
          if (rd_ptr_q == PTR_LAST) begin
            state_d  = ST_IDLE;
            empty_d  = 1'b1;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            fill1_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (fill2_q) begin
        dout_d  = mem_rd_q;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pass_q   <= '0;
      navg_q   <= AVG_W'(1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
      fill1_q  <= 1'b0;
      fill2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      navg_q   <= navg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
      dout_q   <= dout_d;
      fill1_q  <= fill1_d;
      fill2_q  <= fill2_d;
    end
  end

  accum_sat_adder #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .IDX_W  (PTR_W)
  ) u_adder (
    .clk       (clk),
    .rst       (rst),
    .smp_vld   (smp_vld),
    .smp_idx   (wr_ptr_q),
    .smp_dat   (inputData),
    .smp_first (smp_first),
    .acc_in    (mem_rd_q),
    .wr_vld    (wr_vld),
    .wr_idx    (wr_idx),
    .wr_dat    (wr_dat),
    .ovf       (add_ovf)
  );

  // Accumulation and readout never overlap in time, so one read port serves both.
  assign rd_addr = (state_q == ST_DRAIN || state_q == ST_READOUT) ? rd_ptr_q : wr_ptr_q;

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_idx] <= wr_dat;
    mem_rd_q <= mem[rd_addr];
  end

  assign dataReadyToRead = ready_q;
  assign dataEmpty       = empty_q;
  assign dataOut         = dout_q;
  assign captureBusy     = (state_q == ST_CAPTURE) || (state_q == ST_WAIT_TRIG);
  assign overflowFlag    = ovf_q;

endmodule
